il1_refill_ctrl: RTL
====================

# il1_refill_ctrl

Line-refill engine for the L1 instruction cache data array. On an IL1 miss it requests the aligned cache line from the next memory level and streams the returned words into the instruction RAM through its single write port (`update_res`, `IL1_up_index`, `ICRAM_in`). The fetch stage holds the miss until `refill_done` or `refill_err` pulses.

## Interface
Parameters:
- `INDEX_W`, 10: ICRAM word-index width; the array holds 2**INDEX_W words.
- `LINE_WORDS`, 4: words per cache line. Must be a power of two, at least 2.
- `DATA_W`, 32: instruction word width.

Ports:
- `clk`, in, 1: the only clock. All state changes on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `miss_req`, in, 1: IL1 miss. Sampled only in IDLE.
- `miss_addr`, in, 32: byte address of the missing instruction.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `refill_done`, out, 1: one-cycle pulse when a line completes.
- `refill_err`, out, 1: one-cycle pulse when a refill is aborted.
- `mem_req`, out, 1: line read request. Held until granted.
- `mem_addr`, out, 32: line-aligned byte address.
- `mem_gnt`, in, 1: request accepted.
- `mem_rvalid`, in, 1: a data beat is present.
- `mem_rdata`, in, DATA_W: beat data.
- `mem_err`, in, 1: the current beat is erroneous. Qualified by `mem_rvalid`.
- `update_res`, out, 1: ICRAM write enable.
- `IL1_up_index`, out, INDEX_W: ICRAM write index.
- `ICRAM_in`, out, DATA_W: ICRAM write data.

## Operation
- Word index = `miss_addr[INDEX_W+1:2]`.
- Line base index = word index with its low log2(LINE_WORDS) bits cleared.
- `mem_addr` = `miss_addr` with bits [log2(LINE_WORDS)+1:0] cleared.
- FSM states and transitions:
  - IDLE: if `miss_req` is high, capture the base index and `mem_addr`, clear the beat counter, go to REQ.
  - REQ: `mem_req` is high. If `mem_gnt` is high, go to FILL. Otherwise stay in REQ with `mem_addr` stable.
  - FILL: each cycle with `mem_rvalid=1` and `mem_err=0` accepts one beat and increments the beat counter.
    - After the beat with counter = LINE_WORDS-1, go to DONE.
    - A beat with `mem_rvalid=1` and `mem_err=1` goes to ERR and writes nothing.
  - DONE: pulse `refill_done`, go to IDLE.
  - ERR: pulse `refill_err`, go to IDLE. A partially written line remains in the ICRAM; the tag logic must not validate it.
- Beats arrive in ascending word order. The write index is the base index OR'ed with the beat counter, so it never crosses the line boundary or exceeds 2**INDEX_W-1.
- `mem_rvalid` outside FILL is ignored.
- `miss_req` is ignored while `busy` is high.
- `mem_gnt` outside REQ is ignored.

## Timing
- Reset: the FSM goes to IDLE and the beat counter clears. Reset values of outputs:
  - `busy`, `refill_done`, `refill_err`, `mem_req`, `update_res`: 0.
  - `mem_addr`, `IL1_up_index`, `ICRAM_in`: 0.
- Reset mid-refill abandons the line immediately. Outstanding memory beats are the memory side's responsibility.
- The ICRAM write port is registered. A beat accepted at edge N drives `update_res=1` with its index and data during cycle N+1, and the ICRAM commits it at edge N+1.
- `update_res` is 0 in every cycle with no beat accepted on the previous edge. It is never asserted for error beats.
- The last write is presented in the DONE cycle, together with `refill_done`. The full line is readable after that edge.
- Minimum latency, taking cycle 0 as the cycle in which `miss_req` is sampled high:
  - REQ in cycle 1, with `mem_gnt` in cycle 1.
  - Beats in cycles 2 to 5.
  - DONE in cycle 6; `busy` is high in cycles 1 to 6.
- A new miss can be accepted in the first IDLE cycle after DONE or ERR.

## Test plan
- Basic refill: `miss_addr=0x0000_1234`, immediate grant, 4 consecutive beats `A0`..`A3`.
  - `mem_addr=0x0000_1230`.
  - Writes to indices 0x08C, 0x08D, 0x08E, 0x08F in consecutive cycles.
  - `refill_done` in cycle 6; `busy` high in cycles 1 to 6.
- Top of array: `miss_addr=0x0000_0FFC`.
  - `mem_addr=0x0000_0FF0`.
  - Writes to indices 0x3FC to 0x3FF, with no wrap to 0x000.
- Stalls: `mem_gnt` delayed 3 cycles, one idle cycle between beats 1 and 2, and `mem_rvalid` pulsed in IDLE beforehand.
  - `mem_req` is held with a stable address until the grant.
  - Exactly 4 writes, each one cycle after its beat.
  - The IDLE-time `mem_rvalid` is ignored.
- Error: `mem_err=1` on beat 2.
  - Only indices base+0 and base+1 are written.
  - `refill_err` pulses once and `refill_done` stays 0.
  - The FSM returns to IDLE.
- Busy guard: a second `miss_req` during FILL.
  - Ignored; the current line completes unchanged.
  - A miss after DONE starts a new refill.
- Reset mid-FILL: assert `rst` after 2 beats.
  - All outputs go to 0 immediately.
  - No further writes are issued, and the next miss refills normally.

Source files
------------

// File: rtl/il1_refill_ctrl.sv
// IL1 line-refill engine: fetches an aligned line from the next memory level
// and streams its words into the ICRAM write port, one registered write per beat.
module il1_refill_ctrl #(
   parameter int unsigned INDEX_W    = 10,
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned DATA_W     = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               miss_req,
   input  logic [31:0]        miss_addr,
   output logic               busy,
   output logic               refill_done,
   output logic               refill_err,
   output logic               mem_req,
   output logic [31:0]        mem_addr,
   input  logic               mem_gnt,
   input  logic               mem_rvalid,
   input  logic [DATA_W-1:0]  mem_rdata,
   input  logic               mem_err,
   output logic               update_res,
   output logic [INDEX_W-1:0] IL1_up_index,
   output logic [DATA_W-1:0]  ICRAM_in
);

   localparam int unsigned CNT_W = $clog2(LINE_WORDS);

   typedef enum logic [2:0] {StIdle, StReq, StFill, StDone, StErr} state_e;

   state_e              state_q, state_d;
   logic [INDEX_W-1:0]  base_q, base_d;
   logic [31:0]         addr_q, addr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                wr_en_q, wr_en_d;
   logic [INDEX_W-1:0]  wr_idx_q, wr_idx_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_idx_d  = wr_idx_q;
      wr_data_d = wr_data_q;
      unique case (state_q)
         StIdle: begin
            if (miss_req) begin
               base_d  = miss_addr[INDEX_W+1:2] & ~INDEX_W'(LINE_WORDS - 1);
               addr_d  = miss_addr & ~32'(LINE_WORDS * 4 - 1);
               cnt_d   = '0;
               state_d = StReq;
            end
         end
         StReq: begin
            if (mem_gnt) state_d = StFill;
         end
         StFill: begin
            if (mem_rvalid) begin
               if (mem_err) begin
                  state_d = StErr;
               end else begin
                  // OR with the counter keeps the write inside the line
                  wr_en_d   = 1'b1;
                  wr_idx_d  = base_q | INDEX_W'(cnt_q);
                  wr_data_d = mem_rdata;
                  cnt_d     = cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(LINE_WORDS - 1)) state_d = StDone;
               end
            end
         end
         StDone:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         base_q    <= '0;
         addr_q    <= '0;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_idx_q  <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_idx_q  <= wr_idx_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign busy         = (state_q != StIdle);
   assign refill_done  = (state_q == StDone);
   assign refill_err   = (state_q == StErr);
   assign mem_req      = (state_q == StReq);
   assign mem_addr     = addr_q;
   assign update_res   = wr_en_q;
   assign IL1_up_index = wr_idx_q;
   assign ICRAM_in     = wr_data_q;

endmodule
